// File: rtl/la_uart_tx_dump.sv
// rtl/la_uart_tx_dump.sv - streams a sample-RAM block over UART 8N1 as sync, data, checksum.
// Outputs are registered from the current state, so the line lags the internal character timer by one cycle.
module la_uart_tx_dump #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200,
    parameter logic [7:0]  SYNC0    = 8'h55,
    parameter logic [7:0]  SYNC1    = 8'hAA
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic        start,
    input  logic [16:0] start_addr,
    input  logic [16:0] byte_cnt,
    output logic        rd_en,
    output logic [16:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_SYNC0, S_SYNC1, S_DATA, S_CSUM, S_FIN} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [16:0] addr_q, addr_d;
    logic [16:0] rd_left_q, rd_left_d;
    logic [16:0] data_left_q, data_left_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  cur_q, cur_d;
    logic [7:0]  csum_q, csum_d;
    logic        rd_pend_q, rd_pend_d;
    logic        rd_en_q, rd_en_d;
    logic [16:0] rd_addr_q, rd_addr_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  char_byte;
    logic [2:0]  bit_sel;
    logic        char_end;

    always_comb begin
        case (state_q)
            S_SYNC1: char_byte = SYNC1;
            S_DATA:  char_byte = cur_q;
            S_CSUM:  char_byte = csum_q;
            default: char_byte = SYNC0;
        endcase
    end

    assign bit_sel  = 3'(bit_q - 4'd1);
    assign char_end = (baud_q == BAUD_LAST) && (bit_q == 4'd9);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        addr_d      = addr_q;
        rd_left_d   = rd_left_q;
        data_left_d = data_left_q;
        hold_d      = hold_q;
        cur_d       = cur_q;
        csum_d      = csum_q;
        rd_pend_d   = rd_en_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        tx_d        = 1'b1;
        busy_d      = 1'b1;
        done_d      = 1'b0;

        // RAM data arrives one cycle after the strobe; fold it into the checksum as it lands
        if (rd_pend_q) begin
            hold_d = rd_data;
            csum_d = csum_q + rd_data;
        end

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d     = S_SYNC0;
                    baud_d      = '0;
                    bit_d       = 4'd0;
                    addr_d      = start_addr;
                    rd_left_d   = byte_cnt;
                    data_left_d = byte_cnt;
                    csum_d      = 8'h00;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                if (bit_q == 4'd0)      tx_d = 1'b0;
                else if (bit_q == 4'd9) tx_d = 1'b1;
                else                    tx_d = char_byte[bit_sel];

                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    bit_d  = (bit_q == 4'd9) ? 4'd0 : bit_q + 4'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end

                // Prefetch the next data byte at the start of the character before it
                if (baud_q == '0 && bit_q == 4'd0 && rd_left_q != 17'd0 &&
                    (state_q == S_SYNC1 || state_q == S_DATA)) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + 17'd1;
                    rd_left_d = rd_left_q - 17'd1;
                end

                if (char_end) begin
                    case (state_q)
                        S_SYNC0: state_d = S_SYNC1;
                        S_SYNC1: begin
                            if (data_left_q != 17'd0) begin
                                state_d = S_DATA;
                                cur_d   = hold_q;
                            end else begin
                                state_d = S_CSUM;
                            end
                        end
                        S_DATA: begin
                            data_left_d = data_left_q - 17'd1;
                            if (data_left_q == 17'd1) begin
                                state_d = S_CSUM;
                            end else begin
                                state_d = S_DATA;
                                cur_d   = hold_q;
                            end
                        end
                        S_CSUM:  state_d = S_FIN;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= 4'd0;
            addr_q      <= 17'd0;
            rd_left_q   <= 17'd0;
            data_left_q <= 17'd0;
            hold_q      <= 8'h00;
            cur_q       <= 8'h00;
            csum_q      <= 8'h00;
            rd_pend_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= 17'd0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            addr_q      <= addr_d;
            rd_left_q   <= rd_left_d;
            data_left_q <= data_left_d;
            hold_q      <= hold_d;
            cur_q       <= cur_d;
            csum_q      <= csum_d;
            rd_pend_q   <= rd_pend_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign uart_tx = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_la_uart_tx_dump.sv
// tb/tb_la_uart_tx_dump.sv - directed bench for la_uart_tx_dump at 10 clocks per bit.
module tb_la_uart_tx_dump;

    localparam int CPB  = 10;
    localparam int CHAR = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [16:0] start_addr = 17'd0;
    logic [16:0] byte_cnt = 17'd0;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic        uart_tx;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:131071];
    int          n_checks = 0;
    int          n_pass = 0;

    logic        line [0:2047];
    int          done_j;
    logic        busy1, busy_end;
    int          rdj[$];
    logic [16:0] rda[$];

    la_uart_tx_dump #(.CLK_FREQ(1000), .BAUD(100), .SYNC0(8'h55), .SYNC1(8'hAA)) dut (
        .clk_50M(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .byte_cnt(byte_cnt), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .uart_tx(uart_tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Launches one packet and records the line, read strobes and done timing relative to the accept edge
    task automatic do_packet(input logic [16:0] a, input logic [16:0] n, input int ign_at, input int rst_at);
        int maxj;
        maxj = 1 + (int'(n) + 3) * CHAR + 5;
        done_j = -1; busy1 = 1'b0; busy_end = 1'b1;
        rdj.delete(); rda.delete();
        @(negedge clk);
        start = 1'b1; start_addr = a; byte_cnt = n;
        @(posedge clk);
        for (int j = 1; j <= maxj; j++) begin
            @(negedge clk);
            start = (j == ign_at);
            if (j == ign_at) begin start_addr = 17'h0; byte_cnt = 17'd1; end
            if (j == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            line[j] = uart_tx;
            if (j == 1) busy1 = busy;
            if (rd_en) begin rdj.push_back(j); rda.push_back(rd_addr); end
            if (j == rst_at) break;
            if (done) begin done_j = j; busy_end = busy; break; end
        end
    endtask

    task automatic verify(input string nm, input logic [16:0] a, input int n, input logic [7:0] csum_exp);
        logic [7:0]  eb[$];
        logic [7:0]  cb, dec;
        logic [16:0] ad;
        logic        ebit;
        int          errs, j;
        eb.delete();
        eb.push_back(8'h55); eb.push_back(8'hAA);
        for (int k = 0; k < n; k++) begin ad = a + 17'(k); eb.push_back(mem[ad]); end
        eb.push_back(csum_exp);
        check({nm, " done_cycle"}, done_j, 1 + (n + 3) * CHAR);
        check({nm, " busy_at_start"}, busy1, 1'b1);
        check({nm, " busy_at_done"}, busy_end, 1'b0);
        errs = 0;
        for (int m = 0; m < n + 3; m++) begin
            cb = eb[m];
            for (int b = 0; b < 10; b++)
                for (int c = 0; c < CPB; c++) begin
                    j = 1 + m * CHAR + b * CPB + c;
                    ebit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cb[b-1];
                    if (line[j] !== ebit) errs++;
                end
        end
        check({nm, " waveform_errors"}, errs, 0);
        for (int m = 0; m < n + 3; m++) begin
            for (int b = 1; b <= 8; b++) dec[b-1] = line[1 + m * CHAR + b * CPB + 5];
            check($sformatf("%s char%0d", nm, m), dec, eb[m]);
        end
        check({nm, " rd_count"}, rdj.size(), n);
        for (int k = 0; k < n && k < rdj.size(); k++) begin
            check($sformatf("%s rd%0d_cycle", nm, k), rdj[k], 1 + (k + 1) * CHAR);
            ad = a + 17'(k);
            check($sformatf("%s rd%0d_addr", nm, k), rda[k], ad);
        end
    endtask

    task automatic quiet(input string nm, input int cycles);
        int bz, lo, dn;
        bz = 0; lo = 0; dn = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (busy) bz++;
            if (!uart_tx) lo++;
            if (done) dn++;
        end
        check({nm, " quiet_busy"}, bz, 0);
        check({nm, " quiet_line_low"}, lo, 0);
        check({nm, " quiet_done"}, dn, 0);
    endtask

    initial begin
        mem[17'h00100] = 8'h01; mem[17'h00101] = 8'h02; mem[17'h00102] = 8'hFF;
        mem[17'h1FFFE] = 8'h10; mem[17'h1FFFF] = 8'h20;
        mem[17'h00000] = 8'h30; mem[17'h00001] = 8'hF5;
        mem[17'h00200] = 8'h80; mem[17'h00201] = 8'h81;
        mem[17'h00300] = 8'h7E;

        repeat (3) @(posedge clk); #1;
        check("reset uart_tx", uart_tx, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset rd_en", rd_en, 1'b0);
        check("reset rd_addr", rd_addr, 17'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);

        do_packet(17'h00100, 17'd3, 0, 0);
        verify("basic", 17'h00100, 3, 8'h02);
        repeat (5) @(posedge clk);

        do_packet(17'h00050, 17'd0, 0, 0);
        verify("zero", 17'h00050, 0, 8'h00);
        repeat (5) @(posedge clk);

        do_packet(17'h1FFFE, 17'd4, 0, 0);
        verify("wrap", 17'h1FFFE, 4, 8'h55);
        check("wrap rd_addr2", (rda.size() > 2) ? 32'(rda[2]) : 32'hDEAD, 32'h0);
        repeat (5) @(posedge clk);

        do_packet(17'h00100, 17'd3, 150, 0);
        verify("ignored", 17'h00100, 3, 8'h02);
        quiet("ignored", 250);

        do_packet(17'h00100, 17'd3, 0, 1 + 4 * CHAR + 4 * CPB + 5);
        check("midrst uart_tx", uart_tx, 1'b1);
        check("midrst busy", busy, 1'b0);
        check("midrst rd_en", rd_en, 1'b0);
        check("midrst done", done, 1'b0);
        @(negedge clk); rst = 1'b0;
        quiet("midrst", 150);
        do_packet(17'h00100, 17'd3, 0, 0);
        verify("after_rst", 17'h00100, 3, 8'h02);
        repeat (5) @(posedge clk);

        do_packet(17'h00200, 17'd2, 0, 0);
        verify("b2b_a", 17'h00200, 2, 8'h01);
        do_packet(17'h00300, 17'd1, 0, 0);
        verify("b2b_b", 17'h00300, 1, 8'h7E);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
